// File: rtl/conv_param_seq_pkg.sv
// Shared definitions for the convolution parameter sequencer:
// layer codes, default channel counts, FSM state encoding and a
// layer-code legality helper.
package conv_param_seq_pkg;

  localparam logic [3:0] LAYER_NONE  = 4'b0000;
  localparam logic [3:0] LAYER_CONV1 = 4'b0010;
  localparam logic [3:0] LAYER_CONV2 = 4'b0100;
  localparam logic [3:0] LAYER_CONV3 = 4'b0110;

  localparam int DEF_C_MAX1 = 1;
  localparam int DEF_O_MAX1 = 16;
  localparam int DEF_C_MAX2 = 16;
  localparam int DEF_O_MAX2 = 32;
  localparam int DEF_C_MAX3 = 32;
  localparam int DEF_O_MAX3 = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic is_legal_layer(input logic [3:0] code);
    case (code)
      LAYER_CONV1, LAYER_CONV2, LAYER_CONV3: is_legal_layer = 1'b1;
      default:                               is_legal_layer = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conv_param_seq_chan.sv
// chan_counter: nested channel counter, c innermost and o outermost.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous return to (c=0, o=0)
//   advance         step to the next address
//   c_last, o_last  highest index of each counter for the active layer
//   c, o            current address
//   c_wrap, o_wrap  current address sits on the last index of c / o
module chan_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  input  logic [5:0] c_last,
  input  logic [5:0] o_last,
  output logic [5:0] c,
  output logic [5:0] o,
  output logic       c_wrap,
  output logic       o_wrap
);

  assign c_wrap = (c == c_last);
  assign o_wrap = (o == o_last);

  // Address stepping: c wraps into an o increment; o wraps to 0 after the last sweep row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= 6'd0;
      o <= 6'd0;
    end else if (clear) begin
      c <= 6'd0;
      o <= 6'd0;
    end else if (advance) begin
      if (c_wrap) begin
        c <= 6'd0;
        o <= o_wrap ? 6'd0 : o + 6'd1;
      end else begin
        c <= c + 6'd1;
      end
    end
  end

endmodule

// File: rtl/conv_param_seq.sv
// conv_param_seq: sweeps weight-memory addresses for one conv layer and
// presents each fetched weight as a valid/ready beat to the MAC.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, layer       sweep request and its layer code
//   abort              cancel an active sweep
//   out_ready          MAC accepts the presented beat
//   mem_en, mem_state  weight-memory read enable and layer select
//   read_c, read_o     address being issued
//   w_valid            memory output holds a valid weight
//   beat_c, beat_o     address of the presented beat
//   last_c, last       final channel of beat_o / final beat of the layer
//   busy, done, err    sweep active / sweep complete pulse / bad layer pulse
module conv_param_seq
  import conv_param_seq_pkg::*;
#(
  parameter int C_MAX1 = DEF_C_MAX1,
  parameter int O_MAX1 = DEF_O_MAX1,
  parameter int C_MAX2 = DEF_C_MAX2,
  parameter int O_MAX2 = DEF_O_MAX2,
  parameter int C_MAX3 = DEF_C_MAX3,
  parameter int O_MAX3 = DEF_O_MAX3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] layer,
  input  logic       abort,
  input  logic       out_ready,
  output logic       mem_en,
  output logic [3:0] mem_state,
  output logic [5:0] read_c,
  output logic [5:0] read_o,
  output logic       w_valid,
  output logic [5:0] beat_c,
  output logic [5:0] beat_o,
  output logic       last_c,
  output logic       last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state;
  logic [5:0] c_last;
  logic [5:0] o_last;
  logic       c_wrap;
  logic       o_wrap;
  logic       cnt_clear;

  // A new read may issue when the output slot is empty or is being drained this cycle.
  assign mem_en    = (state == RUN) && (!w_valid || out_ready);
  assign cnt_clear = (state == IDLE) && start && is_legal_layer(layer);

  // Counter limits follow the latched layer; the counter is cleared at start so stale limits in IDLE are harmless.
  always_comb begin
    c_last = 6'd0;
    o_last = 6'd0;
    case (mem_state)
      LAYER_CONV1: begin c_last = 6'(C_MAX1 - 1); o_last = 6'(O_MAX1 - 1); end
      LAYER_CONV2: begin c_last = 6'(C_MAX2 - 1); o_last = 6'(O_MAX2 - 1); end
      LAYER_CONV3: begin c_last = 6'(C_MAX3 - 1); o_last = 6'(O_MAX3 - 1); end
      default:     begin c_last = 6'd0;           o_last = 6'd0;           end
    endcase
  end

  chan_counter u_chan_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (mem_en),
    .c_last  (c_last),
    .o_last  (o_last),
    .c       (read_c),
    .o       (read_o),
    .c_wrap  (c_wrap),
    .o_wrap  (o_wrap)
  );

  // Sweep FSM with registered beat tags, valid flag and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_state <= LAYER_NONE;
      w_valid   <= 1'b0;
      beat_c    <= 6'd0;
      beat_o    <= 6'd0;
      last_c    <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // abort is deliberately not looked at here, so start wins a tie.
          if (start) begin
            if (is_legal_layer(layer)) begin
              mem_state <= layer;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              mem_state <= LAYER_NONE;
              err       <= 1'b1;
            end
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            w_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (mem_en) begin
            // Tags are captured with the read so they line up with the memory output next cycle.
            w_valid <= 1'b1;
            beat_c  <= read_c;
            beat_o  <= read_o;
            last_c  <= c_wrap;
            last    <= c_wrap && o_wrap;
            if (c_wrap && o_wrap) begin
              state <= DRAIN;
            end
          end else if (w_valid && out_ready) begin
            w_valid <= 1'b0;
            if ((state == DRAIN) && last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          w_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_param_seq.sv
// Directed self-checking bench for conv_param_seq. Inputs are driven and
// outputs sampled just after the falling edge, away from the active edge.
module tb_conv_param_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] layer;
  logic       abort;
  logic       out_ready;
  logic       mem_en;
  logic [3:0] mem_state;
  logic [5:0] read_c;
  logic [5:0] read_o;
  logic       w_valid;
  logic [5:0] beat_c;
  logic [5:0] beat_o;
  logic       last_c;
  logic       last;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  conv_param_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer     (layer),
    .abort     (abort),
    .out_ready (out_ready),
    .mem_en    (mem_en),
    .mem_state (mem_state),
    .read_c    (read_c),
    .read_o    (read_o),
    .w_valid   (w_valid),
    .beat_c    (beat_c),
    .beat_o    (beat_o),
    .last_c    (last_c),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // mode 0: out_ready always 1; mode 1: fixed irregular stall pattern;
  // mode 2: out_ready low for 5 cycles on the final beat.
  // abort_at >= 0 aborts while beat number abort_at is presented.
  task automatic sweep(input logic [3:0] lay, input int cmax, input int omax,
                       input int mode, input int abort_at, input bit start_abort,
                       input int exp_lat);
    int total;
    int seen;
    int ec;
    int eo;
    int k;
    int stall;
    int done_at;
    bit fin_acc;
    bit prev_stall;
    bit aborted;
    logic [31:0] snap;
    logic [31:0] cur;
    total = cmax * omax;
    seen = 0; ec = 0; eo = 0; k = 0; stall = 0; done_at = -1;
    fin_acc = 1'b0; prev_stall = 1'b0; aborted = 1'b0; snap = 32'd0;
    @(negedge clk);
    start = 1'b1; layer = lay; abort = start_abort; out_ready = 1'b1;
    while (k < total * 4 + 100 && done_at < 0 && !aborted) begin
      @(negedge clk);
      k++;
      start = (k == 40);   // a start mid-sweep must be ignored
      abort = 1'b0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((k % 5) != 2) && ((k % 7) != 3);
        default: begin
          if (w_valid && seen == total - 1 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (abort_at >= 0 && seen == abort_at && w_valid) abort = 1'b1;
      #1;
      if (k == 1) check("busy_after_start", busy, 1);
      check("done_pulse", done, fin_acc);
      if (fin_acc) begin
        done_at = k;
        check("busy_after_done", busy, 0);
      end
      cur = {beat_c, beat_o, last_c, last, read_c, read_o, w_valid, busy, mem_state};
      if (prev_stall) check("stall_stable", cur, snap);
      prev_stall = w_valid && !out_ready;
      snap = cur;
      if (w_valid && !out_ready) check("stall_mem_en", mem_en, 0);
      fin_acc = 1'b0;
      if (abort) begin
        aborted = 1'b1;
      end else if (w_valid && out_ready) begin
        check("beat_c", beat_c, ec);
        check("beat_o", beat_o, eo);
        check("last_c", last_c, (ec == cmax - 1) ? 1 : 0);
        check("last", last, (ec == cmax - 1 && eo == omax - 1) ? 1 : 0);
        check("mem_state", mem_state, lay);
        if (seen == total - 1) fin_acc = 1'b1;
        seen++;
        if (ec == cmax - 1) begin
          ec = 0;
          eo++;
        end else begin
          ec++;
        end
      end
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_w_valid", w_valid, 0);
      check("abort_mem_en", mem_en, 0);
      check("abort_done", done, 0);
      check("abort_beats", seen, abort_at);
      repeat (3) begin
        @(negedge clk);
        #1;
        check("abort_no_done", done, 0);
      end
    end else begin
      check("sweep_done_seen", (done_at > 0) ? 1 : 0, 1);
      check("beat_count", seen, total);
      if (exp_lat > 0) check("latency", done_at, exp_lat);
      @(negedge clk);
      #1;
      check("done_one_cycle", done, 0);
      check("idle_mem_en", mem_en, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; layer = 4'b0000; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_state", mem_state, 0);
    check("rst_read_c", read_c, 0);
    check("rst_read_o", read_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal layer code
    @(negedge clk);
    start = 1'b1; layer = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_mem_en", mem_en, 0);
    check("err_mem_state", mem_state, 0);
    @(negedge clk);
    #1;
    check("err_one_cycle", err, 0);
    check("err_still_idle", busy, 0);

    // abort while idle does nothing
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("idle_abort_busy", busy, 0);

    sweep(4'b0010, 1, 16, 0, -1, 1'b0, 18);
    sweep(4'b0100, 16, 32, 1, -1, 1'b0, -1);
    sweep(4'b0110, 32, 64, 0, 700, 1'b0, -1);
    sweep(4'b0110, 32, 64, 0, -1, 1'b1, 2050);
    sweep(4'b0010, 1, 16, 2, -1, 1'b0, 23);

    // Reset mid-CONV2 while stalled
    @(negedge clk);
    start = 1'b1; layer = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_w_valid", w_valid, 1);
    check("pre_rst_read_c", read_c, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_state", mem_state, 0);
    check("mid_rst_read_c", read_c, 0);
    check("mid_rst_read_o", read_o, 0);
    check("mid_rst_w_valid", w_valid, 0);
    check("mid_rst_beat", {beat_c, beat_o, last_c, last}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_mem_en", mem_en, 0);
    check("post_rst_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_param_seq.md
CONV_PARAM_SEQ -- requirements
Module: conv_param_seq

Interface
REQ-001 Parameter C_MAX1, default 1: CONV1 input channels per output channel.
REQ-002 Parameter O_MAX1, default 16: CONV1 output channels.
REQ-003 Parameters C_MAX2/O_MAX2, defaults 16/32: CONV2 input/output channels.
REQ-004 Parameters C_MAX3/O_MAX3, defaults 32/64: CONV3 input/output channels.
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a layer sweep.
- layer  in  4  layer code sampled with start: 4'b0010 CONV1, 4'b0100 CONV2, 4'b0110 CONV3.
- abort  in  1  synchronous sweep cancel.
- out_ready  in  1  downstream MAC accepts a beat.
- mem_en  out  1  weight-memory read enable.
- mem_state  out  4  layer code driven to the weight and bias memories.
- read_c  out  6  input-channel address.
- read_o  out  6  output-channel address.
- w_valid  out  1  weight word on memory output is valid.
- beat_c  out  6  channel index of the presented beat.
- beat_o  out  6  output index of the presented beat.
- last_c  out  1  presented beat is the final input channel of beat_o.
- last  out  1  presented beat is the final beat of the layer.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.
- err  out  1  one-cycle pulse when start carries an illegal layer code.

Function
REQ-007 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-008 In IDLE, start with a legal layer SHALL latch mem_state, clear the c/o counters, and enter RUN on the next cycle.
REQ-009 In IDLE, start with an illegal layer SHALL pulse err for one cycle and leave the FSM in IDLE with mem_state = 4'b0000.
REQ-010 start outside IDLE SHALL be ignored.
REQ-011 Address order SHALL run with c innermost (0..C_MAX-1) and o outermost (0..O_MAX-1), for C_MAX*O_MAX issues in total.
REQ-012 Issue condition: mem_en = (state==RUN) && (!w_valid || out_ready), combinational.
- read_c/read_o advance only in a cycle where mem_en=1.
REQ-013 The weight memory SHALL be treated as a 1-cycle-latency read:
- w_valid is set the cycle after mem_en=1.
- w_valid clears after a cycle with w_valid && out_ready && !mem_en.
- w_valid holds otherwise; the memory output holds while mem_en=0.
REQ-014 beat_c, beat_o, last_c and last SHALL be registered on mem_en from the issued address, so they stay aligned with the memory output.
REQ-015 On issue of the final address (c=C_MAX-1, o=O_MAX-1), the FSM SHALL enter DRAIN.
REQ-016 In DRAIN, mem_en SHALL be 0; acceptance of the beat with last=1 SHALL pulse done, clear busy and return to IDLE in the same edge.
REQ-017 While held off by out_ready=0, all outputs SHALL stay stable.
REQ-018 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-019 abort in RUN or DRAIN SHALL force IDLE next cycle with w_valid=0, mem_en=0 and no done pulse; abort in IDLE has no effect.
REQ-020 If abort coincides with start in IDLE, start SHALL win.
REQ-021 When C_MAX=1, the c counter SHALL stay 0 and last_c SHALL be 1 on every beat.
REQ-022 Throughput SHALL be one beat per cycle with out_ready held at 1; sweep latency from start to done = C_MAX*O_MAX+2 cycles.

Reset
REQ-023 rst_n low SHALL asynchronously force:
- FSM to IDLE.
- All counters, beat_c/beat_o, mem_state, read_c/read_o to 0.
- w_valid, last_c, last, busy, done, err to 0.
REQ-024 Reset mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-025 A shared package SHALL hold:
- Layer codes LAYER_CONV1/2/3.
- Default channel counts.
- The FSM state enumeration.
REQ-026 One sub-module, chan_counter (nested c/o counter with wrap and last flags), SHALL be instantiated once.

Verification
REQ-027 CONV1 with out_ready=1: start, layer=0010 -> 16 beats with o=0..15 and c=0, last_c=1 on all beats, last on o=15, done exactly 18 cycles after start.
REQ-028 CONV2 with random out_ready: -> 512 beats in c-inner order, no beat duplicated or dropped, last_c at c=15, and outputs stable during every stall.
REQ-029 start with layer=0011 -> err pulse, busy stays 0, no mem_en.
REQ-030 CONV3 with abort at beat 700 -> IDLE next cycle, w_valid=0, no done; a fresh CONV3 sweep then runs all 2048 beats.
REQ-031 rst_n asserted mid-CONV2 with out_ready=0 -> all outputs 0 immediately, FSM IDLE.
REQ-032 CONV1 with out_ready=0 held 5 cycles on the final beat -> done pulses only on the acceptance edge.
